// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path (and future TX).
//   parity_e   : parity mode encoding (0 none, 1 even, 2 odd)
//   rx_state_e : receiver FSM states, including BREAK (used only with break detection)
//   majority3  : 2-of-3 vote used for oversampled bit decisions
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: sample-tick generator shared by the UART receive and transmit paths.
//   clk      in   clock, rising edge
//   rx_reset in   synchronous active-high reset
//   clear    in   restart the tick period (counter to 0, divisor re-latched)
//   cfg_div  in   clk cycles per tick; 0 behaves as 1
//   tick     out  1-cycle pulse when the counter wraps
// The divisor is latched only at a wrap or a clear, so a cfg_div change never
// produces a truncated or stretched period mid-way.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rx_reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] lim_q;
    logic [DIV_W-1:0] lim_d;
    logic             wrap;

    assign lim_d = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    assign wrap  = (cnt_q >= lim_q - DIV_W'(1));
    assign tick  = wrap & ~clear;

    always_ff @(posedge clk) begin
        if (rx_reset) begin
            cnt_q <= '0;
            lim_q <= DIV_W'(1);
        end else if (clear || wrap) begin
            cnt_q <= '0;
            lim_q <= lim_d;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with majority-vote sampling, false-start
// rejection, optional parity, framing/overrun status and a 1-entry valid/ready hold.
//   clk        in   single clock, rising edge
//   rx_reset   in   synchronous active-high reset
//   rx_enable  in   0 holds the receiver idle and aborts a frame in progress
//   cfg_div    in   clk cycles per sample tick (0 behaves as 1)
//   rx_serial  in   asynchronous serial line, idle high
//   rx_data    out  received payload (LSB first on the line)
//   rx_valid   out  rx_data/rx_perr/rx_ferr held until rx_ready
//   rx_ready   in   consumer accepts when rx_valid & rx_ready
//   rx_perr    out  parity error of held frame
//   rx_ferr    out  framing error of held frame
//   rx_overrun out  1-cycle pulse: completed frame dropped because hold was full
//   rx_break   out  1-cycle pulse on a detected break
// Build option: define UART_RX_BREAK_DET_EN to enable break detection; otherwise
// rx_break stays 0 and an all-zero frame is delivered as data with rx_ferr set.
//
// state     | meaning
// RX_IDLE   | line idle, waiting for a synchronised falling edge
// RX_START  | validating start bit; voted 1 means false start
// RX_DATA   | shifting in payload bits, LSB first
// RX_PARITY | sampling parity bit (never entered without parity)
// RX_STOP   | sampling stop bit(s); frame completes at mid-sample of the last
// RX_BREAK  | break seen, waiting for one full bit time of high line
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_MODE  = 0,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = 16
) (
    input  logic                    clk,
    input  logic                    rx_reset,
    input  logic                    rx_enable,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic                    rx_serial,
    output logic [PAYLOAD_BITS-1:0] rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    rx_perr,
    output logic                    rx_ferr,
    output logic                    rx_overrun,
    output logic                    rx_break
);

`ifdef UART_RX_BREAK_DET_EN
    localparam bit BREAK_EN = 1'b1;
`else
    localparam bit BREAK_EN = 1'b0;
`endif

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(PAYLOAD_BITS);
    localparam logic [SW-1:0] SMP_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMP_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(PAYLOAD_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam bit            HAS_PAR   = (PARITY_MODE != int'(PAR_NONE));

    rx_state_e               state_q;
    logic                    sync1_q;
    logic                    sync2_q;
    logic                    prev_q;
    logic [SW-1:0]           samp_q;
    logic [SW-1:0]           samp_d;
    logic                    s_lo_q;
    logic                    s_mid_q;
    logic [PAYLOAD_BITS-1:0] shift_q;
    logic [PAYLOAD_BITS-1:0] shift_d;
    logic [BW-1:0]           bit_cnt_q;
    logic                    par_q;
    logic                    any_one_q;
    logic                    stop_cnt_q;
    logic                    ferr_acc_q;
    logic                    ferr_d;
    logic                    perr_d;
    logic [PAYLOAD_BITS-1:0] data_q;
    logic                    valid_q;
    logic                    perr_q;
    logic                    ferr_q;
    logic                    ovr_q;
    logic                    brk_q;

    logic tick;
    logic start_det;
    logic vote;

    assign start_det = rx_enable & (state_q == RX_IDLE) & prev_q & ~sync2_q;
    // third sample is taken live on the mid-high tick, so the decision costs no extra cycle
    assign vote      = majority3(s_lo_q, s_mid_q, sync2_q);
    assign samp_d    = (samp_q == SMP_LAST) ? '0 : samp_q + SW'(1);
    assign shift_d   = {vote, shift_q[PAYLOAD_BITS-1:1]};
    assign ferr_d    = ferr_acc_q | ~vote;
    // par_q already includes the parity bit by the time the stop bit completes
    assign perr_d    = (PARITY_MODE == int'(PAR_EVEN)) ? par_q :
                       (PARITY_MODE == int'(PAR_ODD))  ? ~par_q : 1'b0;

    uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
        .clk      (clk),
        .rx_reset (rx_reset),
        .clear    (start_det),
        .cfg_div  (cfg_div),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rx_reset) begin
            state_q    <= RX_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            samp_q     <= '0;
            s_lo_q     <= 1'b1;
            s_mid_q    <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            any_one_q  <= 1'b0;
            stop_cnt_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;

            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end

            if (!rx_enable) begin
                state_q <= RX_IDLE;
            end else begin
                case (state_q)
                    RX_IDLE: begin
                        if (start_det) begin
                            state_q <= RX_START;
                            samp_q  <= '0;
                        end
                    end
                    RX_BREAK: begin
                        // any low sample restarts the full-bit high window
                        if (tick) begin
                            if (!sync2_q) begin
                                samp_q <= '0;
                            end else if (samp_q == SMP_LAST) begin
                                state_q <= RX_IDLE;
                            end else begin
                                samp_q <= samp_q + SW'(1);
                            end
                        end
                    end
                    default: begin
                        if (tick) begin
                            samp_q <= samp_d;
                            if (samp_q == SMP_LO) s_lo_q <= sync2_q;
                            if (samp_q == SMP_MID) s_mid_q <= sync2_q;
                            if (samp_q == SMP_HI) begin
                                case (state_q)
                                    RX_START: begin
                                        if (vote) begin
                                            state_q <= RX_IDLE;
                                        end else begin
                                            state_q   <= RX_DATA;
                                            bit_cnt_q <= '0;
                                            par_q     <= 1'b0;
                                            any_one_q <= 1'b0;
                                        end
                                    end
                                    RX_DATA: begin
                                        shift_q   <= shift_d;
                                        par_q     <= par_q ^ vote;
                                        any_one_q <= any_one_q | vote;
                                        bit_cnt_q <= bit_cnt_q + BW'(1);
                                        if (bit_cnt_q == BIT_LAST) begin
                                            state_q    <= HAS_PAR ? RX_PARITY : RX_STOP;
                                            stop_cnt_q <= 1'b0;
                                            ferr_acc_q <= 1'b0;
                                        end
                                    end
                                    RX_PARITY: begin
                                        par_q     <= par_q ^ vote;
                                        any_one_q <= any_one_q | vote;
                                        state_q   <= RX_STOP;
                                    end
                                    RX_STOP: begin
                                        if (BREAK_EN && !stop_cnt_q && !vote && !any_one_q) begin
                                            brk_q   <= 1'b1;
                                            state_q <= RX_BREAK;
                                            samp_q  <= '0;
                                        end else if (stop_cnt_q == STOP_LAST) begin
                                            state_q <= RX_IDLE;
                                            if (valid_q && !rx_ready) begin
                                                ovr_q <= 1'b1;
                                            end else begin
                                                data_q  <= shift_q;
                                                perr_q  <= perr_d;
                                                ferr_q  <= ferr_d;
                                                valid_q <= 1'b1;
                                            end
                                        end else begin
                                            stop_cnt_q <= stop_cnt_q + 1'b1;
                                            ferr_acc_q <= ferr_d;
                                        end
                                    end
                                    default: state_q <= RX_IDLE;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign rx_perr    = perr_q;
    assign rx_ferr    = ferr_q;
    assign rx_overrun = ovr_q;
    assign rx_break   = brk_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: two receivers (8N1 and 8E1) share one serial line; a frame-level
// model decodes each line pattern per format and tracks hold/overrun/break outcomes.
module tb_uart_rx_ovs;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } frame_t;

`ifdef UART_RX_BREAK_DET_EN
    localparam bit BRK_ON = 1'b1;
`else
    localparam bit BRK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rx_reset;
    logic        rx_enable;
    logic [15:0] cfg_div;
    logic        rx_serial;
    logic        rx_ready;
    logic [7:0]  data0, data1;
    logic        v0, v1, pe0, pe1, fe0, fe1, ov0, ov1, bk0, bk1;

    always #5 clk = ~clk;

    uart_rx_ovs dut0 (
        .clk(clk), .rx_reset(rx_reset), .rx_enable(rx_enable), .cfg_div(cfg_div),
        .rx_serial(rx_serial), .rx_data(data0), .rx_valid(v0), .rx_ready(rx_ready),
        .rx_perr(pe0), .rx_ferr(fe0), .rx_overrun(ov0), .rx_break(bk0)
    );

    uart_rx_ovs #(.PARITY_MODE(1)) dut1 (
        .clk(clk), .rx_reset(rx_reset), .rx_enable(rx_enable), .cfg_div(cfg_div),
        .rx_serial(rx_serial), .rx_data(data1), .rx_valid(v1), .rx_ready(rx_ready),
        .rx_perr(pe1), .rx_ferr(fe1), .rx_overrun(ov1), .rx_break(bk1)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    frame_t got0[$], got1[$], exp0[$], exp1[$];
    int     ovr_got[2] = '{0, 0};
    int     ovr_exp[2] = '{0, 0};
    int     brk_got[2] = '{0, 0};
    int     brk_exp[2] = '{0, 0};
    logic   hold_v[2]  = '{1'b0, 1'b0};
    frame_t hold_f[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rx_reset) begin
            if (v0 && rx_ready) got0.push_back(frame_t'({data0, pe0, fe0}));
            if (v1 && rx_ready) got1.push_back(frame_t'({data1, pe1, fe1}));
            if (ov0) ovr_got[0]++;
            if (ov1) ovr_got[1]++;
            if (bk0) brk_got[0]++;
            if (bk1) brk_got[1]++;
        end
    end

    // bits[0] start, bits[8:1] data LSB first, bits[9], bits[10]; line is idle high afterwards
    function automatic void decode(input logic [10:0] bits, input int pmode,
                                   output logic present, output logic brk, output frame_t f);
        logic pbit, stop;
        present = ~bits[0];
        f.data  = bits[8:1];
        if (pmode == 0) begin
            pbit   = 1'b0;
            stop   = bits[9];
            f.perr = 1'b0;
        end else begin
            pbit   = bits[9];
            stop   = bits[10];
            f.perr = ((^bits[9:1]) != (pmode == 2));
        end
        f.ferr = ~stop;
        brk    = BRK_ON && (f.data == 8'h00) && !pbit && !stop;
    endfunction

    task automatic push_exp(input int d, input frame_t f);
        if (d == 0) exp0.push_back(f);
        else        exp1.push_back(f);
    endtask

    task automatic model_apply(input int d, input logic [10:0] bits);
        logic present, brk;
        frame_t f;
        decode(bits, d, present, brk, f);
        if (present) begin
            if (brk)                 brk_exp[d]++;
            else if (rx_ready)       push_exp(d, f);
            else if (!hold_v[d]) begin
                hold_v[d] = 1'b1;
                hold_f[d] = f;
            end else                 ovr_exp[d]++;
        end
    endtask

    task automatic release_hold();
        for (int d = 0; d < 2; d++) begin
            if (hold_v[d]) push_exp(d, hold_f[d]);
            hold_v[d] = 1'b0;
        end
    endtask

    task automatic cmp_q(input string tag, input frame_t g[$], input frame_t e[$]);
        check_eq($sformatf("%s.count", tag), g.size(), e.size());
        for (int i = 0; i < g.size() && i < e.size(); i++)
            check_eq($sformatf("%s.frame%0d", tag, i), 32'(g[i]), 32'(e[i]));
    endtask

    task automatic compare_all(input string tag);
        cmp_q($sformatf("%s.d0", tag), got0, exp0);
        cmp_q($sformatf("%s.d1", tag), got1, exp1);
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s.ovr%0d", tag, d), ovr_got[d], ovr_exp[d]);
            check_eq($sformatf("%s.brk%0d", tag, d), brk_got[d], brk_exp[d]);
        end
    endtask

    function automatic int lim_now();
        return (cfg_div == 16'd0) ? 1 : int'(cfg_div);
    endfunction

    // value set at loop index c is captured by the synchroniser on the following edge
    task automatic send_bits(input logic [11:0] bits, input int nb, input int spike_bit, input int dis_at);
        int   lim  = lim_now();
        int   blen = 16 * lim;
        logic v;
        for (int c = 0; c < nb * blen; c++) begin
            v = bits[c / blen];
            if (spike_bit >= 0 && c == spike_bit * blen + 9 * lim) v = ~v;
            if (dis_at >= 0 && c == dis_at * blen) rx_enable = 1'b0;
            rx_serial = v;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_bits(input int n);
        rx_serial = 1'b1;
        repeat (n * 16 * lim_now()) @(posedge clk);
        #1;
    endtask

    task automatic glitch(input int len);
        rx_serial = 1'b0;
        repeat (len) @(posedge clk);
        #1;
        idle_bits(2);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic b9, input int spike,
                             input int dis, input string tag);
        logic [10:0] bits;
        bits = {1'b1, b9, d, 1'b0};
        send_bits({1'b1, bits}, 11, spike, dis);
        idle_bits(3);
        if (dis < 0) begin
            model_apply(0, bits);
            model_apply(1, bits);
        end
        rx_enable = 1'b1;
        idle_bits(1);
        compare_all(tag);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   spike, dv;
        logic [7:0] d;
        logic b9;

        rx_reset  = 1'b1;
        rx_enable = 1'b1;
        rx_ready  = 1'b1;
        rx_serial = 1'b1;
        cfg_div   = 16'd4;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst.valid0", v0, 0);
        check_eq("rst.data0", data0, 0);
        check_eq("rst.flags0", {pe0, fe0, ov0, bk0}, 0);
        check_eq("rst.valid1", v1, 0);
        check_eq("rst.flags1", {pe1, fe1, ov1, bk1}, 0);
        rx_reset = 1'b0;
        idle_bits(1);

        run_frame(8'hA5, 1'b1, -1, -1, "a5");
        run_frame(8'h07, 1'b0, -1, -1, "par07");
        run_frame(8'h3C, 1'b0, -1, -1, "stop3c");
        glitch(20);
        compare_all("glitch20");
        run_frame(8'h5A, 1'b1, -1, -1, "after_glitch");
        run_frame(8'h6B, 1'b1, 3, -1, "spike");

        rx_ready = 1'b0;
        run_frame(8'h11, 1'b1, -1, -1, "ovr11");
        run_frame(8'h22, 1'b1, -1, -1, "ovr22");
        check_eq("hold.valid0", v0, hold_v[0]);
        check_eq("hold.data0", data0, hold_f[0].data);
        check_eq("hold.data1", data1, hold_f[1].data);
        rx_ready = 1'b1;
        release_hold();
        repeat (3) @(posedge clk);
        #1;
        compare_all("ovr_accept");

        rx_ready = 1'b0;
        run_frame(8'h33, 1'b1, -1, -1, "hold33");
        check_eq("hold33.valid1", v1, hold_v[1]);
        rx_reset = 1'b1;
        @(posedge clk); #1;
        rx_reset = 1'b0;
        hold_v[0] = 1'b0;
        hold_v[1] = 1'b0;
        check_eq("rst_hold.valid0", v0, 0);
        check_eq("rst_hold.data0", data0, 0);
        check_eq("rst_hold.valid1", v1, 0);
        rx_ready = 1'b1;
        idle_bits(1);

        run_frame(8'h99, 1'b1, -1, 4, "disable");
        run_frame(8'h42, 1'b1, -1, -1, "after_disable");

        cfg_div = 16'd0;
        idle_bits(1);
        run_frame(8'hC3, 1'b1, -1, -1, "div0");

        cfg_div = 16'd4;
        idle_bits(1);
        send_bits(12'h000, 12, -1, -1);
        idle_bits(3);
        model_apply(0, 11'h000);
        model_apply(1, 11'h000);
        compare_all("break");
        run_frame(8'h81, 1'b1, -1, -1, "after_break");

        for (int i = 0; i < 20; i++) begin
            dv      = int'($urandom_range(0, 4));
            cfg_div = 16'(dv);
            idle_bits(1);
            d     = 8'($urandom);
            b9    = 1'($urandom);
            spike = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
            if ($urandom_range(0, 3) == 0) begin
                glitch(int'($urandom_range(1, 6 * lim_now())));
            end
            run_frame(d, b9, spike, -1, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
